// File: rtl/pkg_image_mem.sv
// Shared definitions for the image RAM readout path: default widths,
// output image window and the streamer state encoding.
package pkg_image_mem;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 17;
    localparam int IMG_OUT_BASE   = 70000;
    localparam int IMG_OUT_END    = 86383;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } streamer_state_t;
endpackage

// File: rtl/stream_buf2.sv
// Two-entry register FIFO with show-ahead head; the head entry is always
// slot 0 so the stream outputs come straight from registers.
module stream_buf2 #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_last,
    input  logic                  pop,
    output logic [1:0]            count,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_last,
    output logic                  head_valid
);
    logic [DATA_WIDTH-1:0] tail_data;
    logic                  tail_last;

    // Pops shift the tail into the head, so a stalled head never changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= 2'd0;
            head_data <= '0;
            head_last <= 1'b0;
            tail_data <= '0;
            tail_last <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_data <= push_data;
                        head_last <= push_last;
                    end else begin
                        tail_data <= push_data;
                        tail_last <= push_last;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        head_data <= tail_data;
                        head_last <= tail_last;
                    end
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head_data <= push_data;
                        head_last <= push_last;
                    end else begin
                        head_data <= tail_data;
                        head_last <= tail_last;
                        tail_data <= push_data;
                        tail_last <= push_last;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_valid = (count != 2'd0);
endmodule

// File: rtl/ram_result_streamer.sv
// Walks an address window of the image RAM with synchronous reads and
// streams each byte out on a valid/ready interface with full backpressure.
module ram_result_streamer
    import pkg_image_mem::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH-1:0] end_addr,
    output logic                  ram_r_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    streamer_state_t       state;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] end_q;
    logic                  inflight;
    logic                  inflight_last;
    logic [1:0]            buf_count;
    logic                  pop;
    logic [2:0]            credit;
    logic [2:0]            credit_limit;
    logic                  at_end;

    assign pop          = m_valid & m_ready;
    assign at_end       = (rd_ptr == end_q);
    assign credit       = {1'b0, buf_count} + {2'b00, inflight};
    assign credit_limit = 3'd1 + {2'b00, pop};

    // A read may only issue if the buffer is guaranteed a free slot when its data lands.
    assign ram_r_en = (state == RUN) && (credit <= credit_limit);
    assign ram_addr = ram_r_en ? rd_ptr : '0;
    assign busy     = (state != IDLE);
    assign done     = (state == FIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rd_ptr        <= '0;
            end_q         <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            err           <= 1'b0;
        end else begin
            inflight      <= ram_r_en;
            inflight_last <= ram_r_en && at_end;
            case (state)
                IDLE: begin
                    if (start) begin
                        rd_ptr <= start_addr;
                        end_q  <= end_addr;
                        err    <= (end_addr < start_addr);
                        state  <= (end_addr < start_addr) ? FIN : RUN;
                    end
                end
                RUN: begin
                    // Equality stop keeps a window ending at the top address from wrapping.
                    if (ram_r_en) begin
                        if (at_end) begin
                            state <= DRAIN;
                        end else begin
                            rd_ptr <= rd_ptr + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (!inflight && (buf_count == 2'd0 || (buf_count == 2'd1 && pop))) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    stream_buf2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (ram_data),
        .push_last (inflight_last),
        .pop       (pop),
        .count     (buf_count),
        .head_data (m_data),
        .head_last (m_last),
        .head_valid(m_valid)
    );
endmodule

// File: doc/ram_result_streamer.md
Name: ram_result_streamer

Overview:
- Downstream readout stage of the shared image RAM.
- After the convolution processor finishes, it walks a programmable address window and issues synchronous reads on the RAM read port (1-cycle latency).
- It presents each byte on a valid/ready output stream (UART/DMA/testbench sink) with full backpressure.
- It replaces the simulation-only file dump with synthesisable readout.

Parameters:
- DATA_WIDTH, 8, pixel width; matches RAM data width.
- ADDR_WIDTH, 17, RAM address width; covers the 0..86383 image map.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a transfer; ignored while busy.
- start_addr  in  ADDR_WIDTH  first address; latched on start.
- end_addr  in  ADDR_WIDTH  last address, inclusive; latched on start.
- ram_r_en  out  1  RAM read enable.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_data  in  DATA_WIDTH  RAM read data; valid in the cycle after ram_r_en.
- m_data  out  DATA_WIDTH  stream data.
- m_valid  out  1  stream valid.
- m_last  out  1  high with the beat read from end_addr.
- m_ready  in  1  sink ready.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse after the final beat is accepted.
- err  out  1  sticky; set by an empty window (end_addr < start_addr); cleared by the next accepted start.

Behaviour:
- Reset: all outputs 0; state IDLE; counters and buffer cleared.
- Asynchronous reset mid-transfer aborts the transfer immediately and discards buffered data.
- States:
  - IDLE: start -> latch addresses.
    - end_addr >= start_addr: go to RUN, rd_ptr=start_addr.
    - end_addr < start_addr: go to FIN, set err.
  - RUN: issue reads under credit control. When the read at end_addr issues -> DRAIN.
  - DRAIN: no reads; wait until the in-flight read has landed and the buffer is empty -> FIN.
  - FIN: done=1 for exactly one cycle -> IDLE.
- busy=1 in RUN, DRAIN, and FIN.
- Read issue rule, per cycle in RUN:
  - ram_r_en=1 iff (occupancy + inflight - pop) <= 1.
  - occupancy is the 2-entry buffer count; inflight=1 if ram_r_en was high in the previous cycle; pop=m_valid&m_ready.
  - ram_addr=rd_ptr whenever ram_r_en=1; rd_ptr increments on each issued read.
  - rd_ptr never wraps past end_addr.
- Capture: ram_data is written into the buffer in the cycle after each issued read, unconditionally. The credit rule guarantees a slot is free.
- Output: m_data/m_valid/m_last come from the buffer head, registered.
  - m_data and m_last are held stable while m_valid & !m_ready.
  - m_last is tagged at read-issue time (rd_ptr==end_addr) and travels with the data.
- Latency: start at edge E0 -> first ram_r_en in cycle 1 -> data in cycle 2 -> m_valid in cycle 3.
- Throughput: with m_ready tied high, one beat per cycle, no bubbles.
- N-beat window, no backpressure: done pulses 1 cycle after the last beat is accepted, at cycle N+3.
- Single-address window (start_addr==end_addr): exactly one beat, with m_last=1.
- start while busy: ignored; latched addresses unchanged.
- start in the same cycle as done: ignored; the module is busy in FIN.
- A window reaching 2^ADDR_WIDTH-1 is legal. Termination uses an equality compare, not overflow.
- No write port. The block never drives RAM w_en; the processor must have released the RAM before start.

Decomposition:
- Shared package (pkg_image_mem):
  - DATA_WIDTH, ADDR_WIDTH defaults.
  - IMG_OUT_BASE=70000, IMG_OUT_END=86383.
  - Streamer state enum (IDLE, RUN, DRAIN, FIN).
- One sub-module: stream_buf2, a 2-entry register FIFO with data+last payload, push/pop, count output, and show-ahead head.
- Top: FSM, address counter, credit logic.

Test Plan:
- start_addr=20, end_addr=24, RAM preloaded 20..24 = D0,D1,D1,D1,D1 (hex), m_ready=1 -> five beats D0,D1,D1,D1,D1 on consecutive cycles 3..7; m_last only on the 5th; done at cycle 8; reads at addresses 20..24 only.
- Same window, m_ready toggling 1,0,0,1,... -> identical data order, no drop or duplicate; m_data stable while stalled; never more than 2 outstanding (buffer + in-flight).
- start_addr=end_addr=65555, RAM[65555]=0x65 -> single beat 0x65 with m_last=1; done one cycle after acceptance.
- start_addr=100, end_addr=99 -> no ram_r_en, no m_valid; err=1, done pulse; next valid start clears err.
- rst_n asserted low mid-transfer on the 3rd beat with m_ready=0 -> all outputs 0 asynchronously. After release, start 70000..70003 -> clean 4-beat transfer.
- Second start pulse during RUN with different addresses -> ignored; original window completes unchanged.
